// File: rtl/bk_video_pkg.sv
// Shared pixel codes, shifter geometry and parameter defaults for the BK video shifter.
package bk_video_pkg;

  typedef enum logic [1:0] {
    PIX_BLACK = 2'd0,
    PIX_BLUE  = 2'd1,
    PIX_GREEN = 2'd2,
    PIX_RED   = 2'd3
  } pix_e;

  localparam int SHIFT_LEN       = 8;
  localparam int IRQ_DIV_DEFAULT = 1;
  localparam int IRQ_LEN_DEFAULT = 64;

  // One-hot {R,G,B} for a 2-bit colour pixel; black gives all zeros.
  function automatic logic [2:0] pix_to_rgb(input logic [1:0] p);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (pix_e'(p))
      PIX_BLUE:  rgb = 3'b001;
      PIX_GREEN: rgb = 3'b010;
      PIX_RED:   rgb = 3'b100;
      default:   rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/bk_video_shifter_if.sv
// Pin bundle between the va_037 controller side and the video shifter.
interface bk_video_shifter_if;

  logic [15:0] PIN_nD;
  logic        PIN_WTI;
  logic        PIN_nVSYNC;
  logic        PIN_MONO;
  logic        PIN_IRQEN;
  logic        PIN_nIAK;
  logic        PIN_R;
  logic        PIN_G;
  logic        PIN_B;
  logic [1:0]  PIN_M;
  logic        PIN_nIRQ2;
  logic        PIN_UNDER;

  modport master (
    output PIN_nD, PIN_WTI, PIN_nVSYNC, PIN_MONO, PIN_IRQEN, PIN_nIAK,
    input  PIN_R, PIN_G, PIN_B, PIN_M, PIN_nIRQ2, PIN_UNDER
  );

  modport slave (
    input  PIN_nD, PIN_WTI, PIN_nVSYNC, PIN_MONO, PIN_IRQEN, PIN_nIAK,
    output PIN_R, PIN_G, PIN_B, PIN_M, PIN_nIRQ2, PIN_UNDER
  );

endinterface

// File: rtl/bk_irq2_gen.sv
// VSYNC-derived IRQ2 request: edge detect, divide-by-IRQ_DIV, timed low pulse with acknowledge.
module bk_irq2_gen
  import bk_video_pkg::*;
#(
  parameter int IRQ_DIV = IRQ_DIV_DEFAULT,
  parameter int IRQ_LEN = IRQ_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic n_vsync,
  input  logic irq_en,
  input  logic n_iak,
  output logic n_irq2
);

  logic       vsync_q, vsync_d;
  logic       vsync_prev_q, vsync_prev_d;
  logic       iak_q, iak_d;
  logic       active_q, active_d;
  logic [1:0] div_q, div_d;
  logic [7:0] len_q, len_d;
  logic       rise;
  logic       terminal;

  always_comb begin
    rise         = vsync_q & ~vsync_prev_q;
    terminal     = rise && (div_q == 2'(IRQ_DIV - 1));
    vsync_d      = n_vsync;
    vsync_prev_d = vsync_q;
    iak_d        = ~n_iak;
    div_d        = div_q;
    active_d     = active_q;
    len_d        = len_q;

    if (rise) begin
      div_d = terminal ? 2'd0 : div_q + 2'd1;
    end

    // A retrigger while active just reloads the length, so the output never blips high.
    if (!irq_en) begin
      active_d = 1'b0;
    end else if (terminal) begin
      active_d = 1'b1;
      len_d    = 8'(IRQ_LEN);
    end else if (active_q) begin
      if (iak_q || len_q == 8'd1) begin
        active_d = 1'b0;
      end else begin
        len_d = len_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
      iak_q        <= 1'b0;
      active_q     <= 1'b0;
      div_q        <= 2'd0;
      len_q        <= 8'd0;
    end else begin
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      iak_q        <= iak_d;
      active_q     <= active_d;
      div_q        <= div_d;
      len_q        <= len_d;
    end
  end

  assign n_irq2 = ~active_q;

endmodule

// File: rtl/bk_video_shifter.sv
// Captures a DRAM screen word on WTI and serialises it as colour or mono pixels;
// also hosts the IRQ2 generator and the sticky underrun flag.
module bk_video_shifter
  import bk_video_pkg::*;
#(
  parameter int IRQ_DIV = IRQ_DIV_DEFAULT,
  parameter int IRQ_LEN = IRQ_LEN_DEFAULT
) (
  input  logic              PIN_CLK,
  input  logic              PIN_nR,
  bk_video_shifter_if.slave bus
);

  logic [15:0] data;
  logic [7:0]  e_q, e_d;
  logic [7:0]  o_q, o_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        armed_q, armed_d;
  logic        under_q, under_d;
  logic        r_q, r_d;
  logic        g_q, g_d;
  logic        b_q, b_d;
  logic [1:0]  m_q, m_d;
  logic [1:0]  pix;
  logic [2:0]  rgb;

  always_comb begin
    data    = ~bus.PIN_nD;
    e_d     = e_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    armed_d = armed_q | bus.PIN_WTI;

    if (bus.PIN_WTI) begin
      for (int i = 0; i < SHIFT_LEN; i++) begin
        e_d[i] = data[2*i];
        o_d[i] = data[2*i+1];
      end
      cnt_d  = 4'd0;
      mode_d = bus.PIN_MONO;
    end else if (cnt_q < 4'(SHIFT_LEN)) begin
      e_d   = {1'b0, e_q[7:1]};
      o_d   = {1'b0, o_q[7:1]};
      cnt_d = cnt_q + 4'd1;
    end

    // Running dry without a fresh word is the underrun; reloading on that same edge is fine.
    under_d = under_q | (armed_q && !bus.PIN_WTI && cnt_d == 4'(SHIFT_LEN));

    pix = {o_q[0], e_q[0]};
    rgb = pix_to_rgb(pix);
    if (mode_q) begin
      {r_d, g_d, b_d} = 3'b000;
      m_d             = pix;
    end else begin
      {r_d, g_d, b_d} = rgb;
      m_d             = 2'b00;
    end
  end

  always_ff @(posedge PIN_CLK or negedge PIN_nR) begin
    if (!PIN_nR) begin
      e_q     <= 8'd0;
      o_q     <= 8'd0;
      cnt_q   <= 4'(SHIFT_LEN);
      mode_q  <= 1'b0;
      armed_q <= 1'b0;
      under_q <= 1'b0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      m_q     <= 2'b00;
    end else begin
      e_q     <= e_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      under_q <= under_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      m_q     <= m_d;
    end
  end

  assign bus.PIN_R     = r_q;
  assign bus.PIN_G     = g_q;
  assign bus.PIN_B     = b_q;
  assign bus.PIN_M     = m_q;
  assign bus.PIN_UNDER = under_q;

  bk_irq2_gen #(
    .IRQ_DIV(IRQ_DIV),
    .IRQ_LEN(IRQ_LEN)
  ) u_irq2 (
    .clk    (PIN_CLK),
    .rst_n  (PIN_nR),
    .n_vsync(bus.PIN_nVSYNC),
    .irq_en (bus.PIN_IRQEN),
    .n_iak  (bus.PIN_nIAK),
    .n_irq2 (bus.PIN_nIRQ2)
  );

endmodule

// File: tb/tb_bk_video_shifter.sv
// Directed bench for bk_video_shifter with an edge-indexed reference model checked every cycle.
module tb_bk_video_shifter;

  localparam int IRQ_DIV = 2;
  localparam int IRQ_LEN = 64;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  bk_video_shifter_if bus();

  bk_video_shifter #(
    .IRQ_DIV(IRQ_DIV),
    .IRQ_LEN(IRQ_LEN)
  ) dut (
    .PIN_CLK(clk),
    .PIN_nR (nR),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: outputs after edge n follow from the most recent load edge and the word captured there.
  int          edge_n = 0;
  int          load_edge = 0;
  bit          have_load = 1'b0;
  logic [15:0] word = 16'h0000;
  bit          mode = 1'b0;
  bit          vs_last = 1'b1;
  bit          rise_pending = 1'b0;
  bit          ack_pending = 1'b0;
  int          rises = 0;
  bit          irq_low = 1'b0;
  int          deadline = 0;
  bit          exp_r = 1'b0, exp_g = 1'b0, exp_b = 1'b0, exp_under = 1'b0;
  logic [1:0]  exp_m = 2'b00;

  task automatic modelReset();
    have_load = 1'b0; mode = 1'b0; vs_last = 1'b1; rise_pending = 1'b0;
    ack_pending = 1'b0; rises = 0; irq_low = 1'b0;
    exp_r = 1'b0; exp_g = 1'b0; exp_b = 1'b0; exp_m = 2'b00; exp_under = 1'b0;
  endtask

  task automatic modelStep();
    int         idx;
    logic [1:0] p;
    bit         terminal;
    edge_n++;
    idx = edge_n - load_edge - 1;
    p   = 2'b00;
    if (have_load && idx >= 0 && idx < 8) p = {word[2*idx+1], word[2*idx]};
    exp_r = !mode && (p == 2'd3);
    exp_g = !mode && (p == 2'd2);
    exp_b = !mode && (p == 2'd1);
    exp_m = mode ? p : 2'b00;
    if (!bus.PIN_WTI && have_load && (edge_n - load_edge) >= 8) exp_under = 1'b1;
    if (bus.PIN_WTI) begin
      have_load = 1'b1;
      load_edge = edge_n;
      word      = ~bus.PIN_nD;
      mode      = bus.PIN_MONO;
    end
    terminal = 1'b0;
    if (rise_pending) begin
      rises++;
      terminal = (rises % IRQ_DIV) == 0;
    end
    if (!bus.PIN_IRQEN) irq_low = 1'b0;
    else if (terminal) begin
      irq_low  = 1'b1;
      deadline = edge_n + IRQ_LEN;
    end else if (irq_low && (ack_pending || edge_n >= deadline)) irq_low = 1'b0;
    rise_pending = !vs_last && bus.PIN_nVSYNC;
    vs_last      = bus.PIN_nVSYNC;
    ack_pending  = !bus.PIN_nIAK;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge nR);
      if (!nR) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("cyc_r", int'(bus.PIN_R), int'(exp_r));
        checkOutput("cyc_g", int'(bus.PIN_G), int'(exp_g));
        checkOutput("cyc_b", int'(bus.PIN_B), int'(exp_b));
        checkOutput("cyc_m", int'(bus.PIN_M), int'(exp_m));
        checkOutput("cyc_nirq2", int'(bus.PIN_nIRQ2), int'(!irq_low));
        checkOutput("cyc_under", int'(bus.PIN_UNDER), int'(exp_under));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic mono);
    bus.PIN_WTI  = 1'b1;
    bus.PIN_nD   = ~d;
    bus.PIN_MONO = mono;
    tick();
    bus.PIN_WTI  = 1'b0;
  endtask

  task automatic doReset();
    nR = 1'b0;
    tick();
    tick();
    nR = 1'b1;
  endtask

  task automatic vsyncPulse();
    bus.PIN_nVSYNC = 1'b0;
    tick();
    tick();
    bus.PIN_nVSYNC = 1'b1;
  endtask

  task automatic waitIrqLow(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      if (!bus.PIN_nIRQ2) seen = 1'b1;
    end
    checkOutput(name, int'(seen), 1);
  endtask

  logic [2:0] colour_seq [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  initial begin
    int lowcnt;
    bus.PIN_nD     = 16'hFFFF;
    bus.PIN_WTI    = 1'b0;
    bus.PIN_nVSYNC = 1'b1;
    bus.PIN_MONO   = 1'b0;
    bus.PIN_IRQEN  = 1'b1;
    bus.PIN_nIAK   = 1'b1;
    doReset();
    started = 1'b1;

    checkOutput("reset_rgb", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 0);
    checkOutput("reset_m", int'(bus.PIN_M), 0);
    checkOutput("reset_nirq2", int'(bus.PIN_nIRQ2), 1);
    checkOutput("reset_under", int'(bus.PIN_UNDER), 0);

    $display("[TB] all-green word");
    applyStimulus(16'hAAAA, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("green_run", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 3'b010);
    end
    tick();
    checkOutput("green_after", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 0);

    $display("[TB] colour sequence word");
    applyStimulus(16'b1110_0100_1110_0100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("colour_seq_%0d", i), int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}),
                  int'(colour_seq[i % 4]));
      checkOutput("colour_m", int'(bus.PIN_M), 0);
    end

    $display("[TB] mono word");
    applyStimulus(16'h0003, 1'b1);
    tick();
    checkOutput("mono_first", int'(bus.PIN_M), 3);
    checkOutput("mono_rgb", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("mono_rest", int'(bus.PIN_M), 0);
      checkOutput("mono_rgb", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 0);
    end

    $display("[TB] back-to-back words and underrun");
    doReset();
    applyStimulus(16'hAAAA, 1'b0);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 7; i++) begin
        tick();
        checkOutput("stream_green", int'(bus.PIN_G), 1);
      end
      applyStimulus(16'hAAAA, 1'b0);
      checkOutput("stream_green", int'(bus.PIN_G), 1);
      checkOutput("stream_under", int'(bus.PIN_UNDER), 0);
    end
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(16'hAAAA, 1'b0);
    checkOutput("late_under", int'(bus.PIN_UNDER), 1);
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(16'hAAAA, 1'b0);
    checkOutput("under_sticky", int'(bus.PIN_UNDER), 1);

    $display("[TB] IRQ2 divide and length");
    doReset();
    for (int p = 0; p < 5; p++) begin
      vsyncPulse();
      lowcnt = 0;
      for (int t = 0; t < 80; t++) begin
        tick();
        if (!bus.PIN_nIRQ2) lowcnt++;
      end
      checkOutput($sformatf("irq_len_%0d", p), lowcnt, (p % 2 == 1) ? 64 : 0);
    end

    $display("[TB] IRQ2 acknowledge");
    vsyncPulse();
    waitIrqLow("irq_ack_assert");
    lowcnt = 1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (!bus.PIN_nIRQ2) lowcnt++;
    end
    bus.PIN_nIAK = 1'b0;
    tick();
    if (!bus.PIN_nIRQ2) lowcnt++;
    bus.PIN_nIAK = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (!bus.PIN_nIRQ2) lowcnt++;
    end
    checkOutput("irq_ack_len", lowcnt, 6);

    $display("[TB] asynchronous reset mid-word and mid-IRQ");
    applyStimulus(16'hAAAA, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    vsyncPulse();
    for (int i = 0; i < 10; i++) tick();
    vsyncPulse();
    waitIrqLow("irq_pre_reset");
    applyStimulus(16'b1110_0100_1110_0100, 1'b0);
    tick();
    tick();
    tick();
    #3;
    nR = 1'b0;
    #1;
    checkOutput("arst_rgb", int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}), 0);
    checkOutput("arst_m", int'(bus.PIN_M), 0);
    checkOutput("arst_nirq2", int'(bus.PIN_nIRQ2), 1);
    checkOutput("arst_under", int'(bus.PIN_UNDER), 0);
    tick();
    nR = 1'b1;
    applyStimulus(16'b1110_0100_1110_0100, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("post_reset_%0d", i), int'({bus.PIN_R, bus.PIN_G, bus.PIN_B}),
                  int'(colour_seq[i % 4]));
      if (i < 7) checkOutput("post_reset_under", int'(bus.PIN_UNDER), 0);
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bk_video_shifter.md
# bk_video_shifter

Downstream pixel stage of the 1801VP1-037 video/DRAM controller (va_037). It captures the screen word that DRAM drives onto the data bus when the controller asserts WTI, and serialises it as 2-bit colour pixels or 1-bit mono pixels. It also generates the VSYNC-derived IRQ2 request for the CPU. It replaces the discrete D24/D25 shift registers and the D28/D3 IRQ2 selector of the BK board with one synchronous block.

## Interface
Parameters:
- IRQ_DIV, 1: number of VSYNC rising edges per IRQ2 request (1..4).
- IRQ_LEN, 64: IRQ2 low-pulse length in clocks when not acknowledged (1..255).

Ports:
- PIN_CLK  in  1  system clock; all state on rising edge.
- PIN_nR  in  1  reset, asynchronous, active-low.
- PIN_nD  in  16  DRAM read data, active-low (inverted data as driven by DRAM).
- PIN_WTI  in  1  word load strobe from va_037.
- PIN_nVSYNC  in  1  frame sync from va_037, active-low.
- PIN_MONO  in  1  1 = mono mode, 0 = colour mode; sampled only at load.
- PIN_IRQEN  in  1  IRQ2 enable.
- PIN_nIAK  in  1  IRQ2 acknowledge, active-low.
- PIN_R, PIN_G, PIN_B  out  1 each  colour pixel outputs.
- PIN_M  out  2  mono pixel pair; bit0 is the earlier pixel.
- PIN_nIRQ2  out  1  IRQ2 request, active-low.
- PIN_UNDER  out  1  sticky underrun flag.

## Operation
- Load: on an edge where PIN_WTI=1, capture D = ~PIN_nD.
  - Even bits D[0,2,..,14] go to even shifter E[7:0].
  - Odd bits D[1,3,..,15] go to odd shifter O[7:0].
  - The shift counter is set to 0 and the mode register is set to PIN_MONO.
- Shift: on an edge where PIN_WTI=0 and the counter is below 8, E and O shift right, 0 enters bit 7, and the counter increments. At a counter of 8 the word is exhausted and the shifters hold 0.
- Load has priority over shift when both apply. A load mid-word discards the remaining pixels.
- Pixel value P = {O[0],E[0]}.
- Colour decode:
  - P=00: black (R=G=B=0).
  - P=01: blue.
  - P=10: green.
  - P=11: red.
  - Exactly one of R/G/B is high for any nonzero P.
- Mono mode: PIN_M = P. R/G/B are forced to 0.
- Colour mode: PIN_M = 00.
- Underrun:
  - The underrun check is armed by the first load after reset.
  - Once armed, a counter of 8 with PIN_WTI=0 sets PIN_UNDER. It stays set until reset.
  - A load on the same edge that the counter reaches 8 is not an underrun.
- IRQ2: handled by the IRQ2 sub-block.
  - The sub-block detects the nVSYNC rising edge (registered previous value = 0, current = 1) and counts edges modulo IRQ_DIV.
  - On a terminal edge with PIN_IRQEN=1, PIN_nIRQ2 goes low.
  - PIN_nIRQ2 returns high after IRQ_LEN clocks, or on the edge after PIN_nIAK is sampled low, whichever is first.
  - A new terminal edge while the request is already active restarts the length count without a glitch.
  - Deasserting PIN_IRQEN releases the request on the next edge. It does not reset the divider.

## Timing
- Reset values: E=O=0, counter=8, mode=0, R=G=B=0, PIN_M=00, PIN_nIRQ2=1, PIN_UNDER=0, IRQ divider=0, underrun disarmed, previous nVSYNC register=1.
- Latency: with WTI sampled at edge k, pixel i (i=0..7) appears on the outputs after edge k+1+i. Outputs are registered decodes of E[0]/O[0].
- Back-to-back words: WTI every 8th clock gives a seamless pixel stream with no black gap.
- IRQ2:
  - A VSYNC rising edge at the input, sampled at edge k, makes PIN_nIRQ2 low after edge k+1.
  - A low PIN_nIAK sampled at edge j makes PIN_nIRQ2 high after edge j+1.
- Asynchronous reset mid-word or mid-IRQ immediately returns all outputs to their reset values.

## Structure
- Package bk_video_pkg holds:
  - 2-bit pixel codes PIX_BLACK=0, PIX_BLUE=1, PIX_GREEN=2, PIX_RED=3.
  - Shifter length constant 8.
  - Defaults for IRQ_DIV and IRQ_LEN.
- One sub-module, bk_irq2_gen, contains the VSYNC edge detector, the divider, the pulse counter and the acknowledge logic.
- The shifter, decode and underrun logic stay in the top level.

## Test plan
1. Reset, then colour mode, load PIN_nD=~16'hAAAA (D=AAAA, every pixel P=10) -> PIN_G=1 for 8 clocks starting at the 2nd edge after load, then R=G=B=0.
2. Colour mode, load D=16'b1110_0100_1110_0100 -> pixels 00,01,10,11,00,01,10,11: black,blue,green,red repeated twice, in order.
3. Mono mode, load D=16'h0003 -> PIN_M=11 for the first pixel clock, then 00. R=G=B=0 throughout.
4. Back-to-back loads every 8 clocks give a continuous stream with PIN_UNDER=0. Delay one load by 1 clock -> PIN_UNDER=1 and it stays 1 after later loads.
5. IRQ_DIV=2, PIN_IRQEN=1, pulse nVSYNC 4 times -> exactly 2 PIN_nIRQ2 pulses, each 64 clocks long. Repeat with PIN_nIAK low 5 clocks after assertion -> pulse ends after 6 clocks.
6. Assert PIN_nR mid-word and mid-IRQ -> all outputs return to their reset values immediately. The first load after reset produces correct pixels with no underrun.
